// File: rtl/spi_pkg.sv
// spi_pkg: frame geometry, rw encoding and FSM state codes shared by the SPI initiator
package spi_pkg;
  localparam int FRAME_BITS = 16;
  localparam int ADDR_BITS = 7;
  localparam int DATA_BITS = 8;
  localparam logic RW_READ = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEAD = 3'd1;
  localparam logic [2:0] ST_XFER = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_GAP = 3'd4;
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [ADDR_BITS-1:0] addr,
                                                         input logic rw,
                                                         input logic [DATA_BITS-1:0] wdata);
    return {addr, rw, rw == RW_WRITE ? wdata : {DATA_BITS{1'b0}}};
  endfunction
endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: prescaler counting 0..CLKDIV-1, strobing tick_o on the last count
module spi_clkgen #(
  parameter int CLKDIV = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  localparam int CW = $clog2(CLKDIV);
  logic [CW-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == CW'(CLKDIV - 1);
  // restart on clear or wrap after the tick
  always_comb cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  // count register
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/spi_master.sv
// spi_master: single address/rw/data SPI frame initiator with registered pin outputs
module spi_master
  import spi_pkg::*;
#(
  parameter int CLKDIV = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 rw,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] rdata,
  output logic                 sclk_pin,
  output logic                 cs_pin,
  output logic                 mosi_pin,
  input  logic                 miso_pin
);
  logic [2:0] state_q, state_d;
  logic [FRAME_BITS-1:0] tx_q, tx_d;
  logic [DATA_BITS-1:0] rx_q, rx_d, rdata_q, rdata_d;
  logic [3:0] bit_q, bit_d;
  logic rw_q, rw_d, sclk_q, sclk_d, cs_q, cs_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic tick;
  spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk(clk),
    .reset(reset),
    .clr_i(state_d != state_q),
    .tick_o(tick)
  );
  // frame sequencing: SCLK toggles on ticks, MOSI shifts and MISO is sampled on falling ticks
  always_comb begin
    state_d = state_q;
    tx_d = tx_q;
    rx_d = rx_q;
    bit_d = bit_q;
    rw_d = rw_q;
    sclk_d = sclk_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d = ST_LEAD;
        tx_d = build_frame(addr, rw, wdata);
        rw_d = rw;
        bit_d = 4'd15;
      end
      ST_LEAD: if (tick) begin
        state_d = ST_XFER;
        sclk_d = 1'b1;
      end
      ST_XFER: if (tick) begin
        sclk_d = !sclk_q;
        if (sclk_q) begin
          rx_d = bit_q[3] ? rx_q : {rx_q[DATA_BITS-2:0], miso_pin};
          tx_d = tx_q << 1;
          state_d = bit_q == 4'd0 ? ST_TRAIL : ST_XFER;
          bit_d = bit_q == 4'd0 ? 4'd15 : bit_q - 4'd1;
        end
      end
      ST_TRAIL: if (tick) begin
        state_d = ST_GAP;
        rdata_d = rw_q == RW_READ ? rx_q : rdata_q;
      end
      ST_GAP: if (tick) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    cs_d = !(state_d == ST_LEAD || state_d == ST_XFER || state_d == ST_TRAIL);
    mosi_d = tx_d[FRAME_BITS-1];
    busy_d = state_d != ST_IDLE;
    done_d = state_q == ST_TRAIL && state_d == ST_GAP;
  end
  // state and pin registers, all forced to idle values by reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tx_q <= '0;
      rx_q <= '0;
      bit_q <= 4'd15;
      rw_q <= 1'b0;
      sclk_q <= 1'b0;
      cs_q <= 1'b1;
      mosi_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      rx_q <= rx_d;
      bit_q <= bit_d;
      rw_q <= rw_d;
      sclk_q <= sclk_d;
      cs_q <= cs_d;
      mosi_q <= mosi_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rdata_q <= rdata_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign rdata = rdata_q;
  assign sclk_pin = sclk_q;
  assign cs_pin = cs_q;
  assign mosi_pin = mosi_q;
endmodule
